// File: rtl/mem_access.sv
// Memory-access pipeline stage: turns EX/MEM load/store controls into a single
// request/ack transaction on the data-memory bus and extends returned load data.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALURes_MEM,
  input  logic [31:0] rdata2_MEM,
  input  logic        MemRW_MEM,
  input  logic        Mem2Reg_MEM,
  input  logic [2:0]  MemRdCtrl_MEM,
  input  logic [1:0]  MemWrCtrl_MEM,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] MemData_MEM,
  output logic        mem_stall,
  output logic        misalign
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned SW   = 4;

  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SB  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t            state, state_n;
  logic              req_n, we_n;
  logic [XLEN-1:0]   addr_n, wdata_n;
  logic [SW-1:0]     wstrb_n;
  logic [XLEN-1:0]   load_word, load_word_n;

  logic              op_present, is_load, bad_align;
  logic [XLEN-1:0]   st_wdata;
  logic [SW-1:0]     st_wstrb;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   ld_ext;

  assign op_present = MemRW_MEM | Mem2Reg_MEM;
  assign is_load    = Mem2Reg_MEM & ~MemRW_MEM;

  // Alignment check; a store wins when both controls are set
  always_comb begin
    bad_align = 1'b0;
    if (MemRW_MEM) begin
      case (MemWrCtrl_MEM)
        ST_SH:   bad_align = ALURes_MEM[0];
        ST_SB:   bad_align = 1'b0;
        default: bad_align = |ALURes_MEM[1:0];
      endcase
    end else if (Mem2Reg_MEM) begin
      case (MemRdCtrl_MEM)
        LD_LH, LD_LHU: bad_align = ALURes_MEM[0];
        LD_LB, LD_LBU: bad_align = 1'b0;
        default:       bad_align = |ALURes_MEM[1:0];
      endcase
    end
  end

  assign misalign = op_present & bad_align;

  // Store data is replicated across lanes; the strobe picks the live bytes
  always_comb begin
    st_wdata = rdata2_MEM;
    st_wstrb = 4'b1111;
    case (MemWrCtrl_MEM)
      ST_SH: begin
        st_wdata = {2{rdata2_MEM[15:0]}};
        st_wstrb = ALURes_MEM[1] ? 4'b1100 : 4'b0011;
      end
      ST_SB: begin
        st_wdata = {4{rdata2_MEM[7:0]}};
        st_wstrb = 4'b0001 << ALURes_MEM[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = 8'(load_word >> {ALURes_MEM[1:0], 3'b000});
    ld_half = ALURes_MEM[1] ? load_word[31:16] : load_word[15:0];
    case (MemRdCtrl_MEM)
      LD_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      LD_LHU:  ld_ext = {16'h0000, ld_half};
      LD_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU:  ld_ext = {24'h000000, ld_byte};
      default: ld_ext = load_word;
    endcase
  end

  assign MemData_MEM = (state == DONE && is_load) ? ld_ext : '0;
  assign mem_stall   = op_present & ~misalign & (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
      load_word  <= '0;
    end else begin
      state      <= state_n;
      dmem_req   <= req_n;
      dmem_we    <= we_n;
      dmem_addr  <= addr_n;
      dmem_wdata <= wdata_n;
      dmem_wstrb <= wstrb_n;
      load_word  <= load_word_n;
    end
  end

  // Request fields are loaded once in IDLE and held until the ack
  always_comb begin
    state_n     = state;
    req_n       = dmem_req;
    we_n        = dmem_we;
    addr_n      = dmem_addr;
    wdata_n     = dmem_wdata;
    wstrb_n     = dmem_wstrb;
    load_word_n = load_word;
    case (state)
      IDLE: begin
        if (op_present && !bad_align) begin
          state_n = BUSY;
          req_n   = 1'b1;
          we_n    = MemRW_MEM;
          addr_n  = {ALURes_MEM[31:2], 2'b00};
          wdata_n = MemRW_MEM ? st_wdata : '0;
          wstrb_n = MemRW_MEM ? st_wstrb : 4'b0000;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_n     = DONE;
          req_n       = 1'b0;
          load_word_n = dmem_rdata;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a scoreboard of expected bus requests and load results.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALURes_MEM, rdata2_MEM;
  logic        MemRW_MEM, Mem2Reg_MEM;
  logic [2:0]  MemRdCtrl_MEM;
  logic [1:0]  MemWrCtrl_MEM;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] MemData_MEM;
  logic        mem_stall, misalign;

  mem_access dut (
    .clk(clk), .rst(rst),
    .ALURes_MEM(ALURes_MEM), .rdata2_MEM(rdata2_MEM),
    .MemRW_MEM(MemRW_MEM), .Mem2Reg_MEM(Mem2Reg_MEM),
    .MemRdCtrl_MEM(MemRdCtrl_MEM), .MemWrCtrl_MEM(MemWrCtrl_MEM),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .MemData_MEM(MemData_MEM), .mem_stall(mem_stall), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  req_t        req_q[$];
  logic [31:0] res_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic st, input logic ld, input logic [2:0] rd,
                        input logic [1:0] wr, input logic [31:0] a, input logic [31:0] d);
    MemRW_MEM     = st;
    Mem2Reg_MEM   = ld;
    MemRdCtrl_MEM = rd;
    MemWrCtrl_MEM = wr;
    ALURes_MEM    = a;
    rdata2_MEM    = d;
  endtask

  // Drives one aligned op, plays the memory with `waits` wait cycles, checks bus and result
  task automatic access(input string tag, input logic st, input logic ld, input logic [2:0] rd,
                        input logic [1:0] wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rdata, input int waits, input req_t exp_req,
                        input logic [31:0] exp_res, output int req_cyc);
    req_t        e;
    logic [31:0] er;
    int          stalls = 0;
    int          busy = 0;
    bit          seen = 0;
    bit          done = 0;
    req_q.push_back(exp_req);
    res_q.push_back(exp_res);
    set_op(st, ld, rd, wr, a, d);
    req_cyc = -1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (dmem_req) begin
        if (!seen) begin
          seen    = 1;
          req_cyc = cyc;
          e       = req_q.pop_front();
          check({tag, " addr"}, dmem_addr, e.addr);
          check({tag, " we"}, 32'(dmem_we), 32'(e.we));
          check({tag, " wstrb"}, 32'(dmem_wstrb), 32'(e.wstrb));
          if (e.we) check({tag, " wdata"}, dmem_wdata, e.wdata);
        end
        if (mem_stall) stalls++;
        dmem_ack   = (busy == waits);
        dmem_rdata = rdata;
        busy++;
      end else begin
        dmem_ack = 1'b0;
        if (seen && !mem_stall) begin
          done = 1;
          er   = res_q.pop_front();
          check({tag, " result"}, MemData_MEM, er);
        end else if (mem_stall) begin
          stalls++;
        end
      end
    end
    dmem_ack = 1'b0;
    check({tag, " completed"}, 32'(done), 32'd1);
    check({tag, " stall cycles"}, 32'(stalls), 32'(2 + waits));
    check({tag, " req cycles"}, 32'(busy), 32'(waits + 1));
  endtask

  task automatic misaligned(input string tag, input logic [2:0] rd, input logic [31:0] a);
    set_op(1'b0, 1'b1, rd, 2'b00, a, 32'h0);
    for (int c = 0; c < 3; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      check({tag, " req"}, 32'(dmem_req), 32'd0);
      check({tag, " misalign"}, 32'(misalign), 32'd1);
      check({tag, " stall"}, 32'(mem_stall), 32'd0);
      check({tag, " result"}, MemData_MEM, 32'h0);
    end
    set_op(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
  endtask

  initial begin
    req_t r;
    int   c1, c2, cr;
    bit   got;
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    set_op(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("reset req", 32'(dmem_req), 32'd0);
    check("reset we", 32'(dmem_we), 32'd0);
    check("reset addr", dmem_addr, 32'h0);
    check("reset wdata", dmem_wdata, 32'h0);
    check("reset wstrb", 32'(dmem_wstrb), 32'd0);
    check("reset memdata", MemData_MEM, 32'h0);
    check("reset stall", 32'(mem_stall), 32'd0);
    check("reset misalign", 32'(misalign), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    r = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111};
    access("SW", 1'b1, 1'b0, 3'b000, 2'b00, 32'h100, 32'hDEAD_BEEF, 32'h5555_5555, 0, r, 32'h0, c1);
    r = '{1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 4'b1000};
    access("SB", 1'b1, 1'b0, 3'b000, 2'b10, 32'h203, 32'h0000_00A5, 32'h0, 0, r, 32'h0, c1);
    r = '{1'b1, 32'h0000_0600, 32'h5678_5678, 4'b1100};
    access("SH", 1'b1, 1'b0, 3'b000, 2'b01, 32'h602, 32'h1234_5678, 32'h0, 1, r, 32'h0, c1);
    r = '{1'b0, 32'h0000_0300, 32'h0, 4'b0000};
    access("LB", 1'b0, 1'b1, 3'b011, 2'b00, 32'h302, 32'h0, 32'h1280_7F34, 3, r, 32'hFFFF_FF80, c1);
    access("LBU", 1'b0, 1'b1, 3'b100, 2'b00, 32'h302, 32'h0, 32'h1280_7F34, 3, r, 32'h0000_0080, c1);
    set_op(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    @(negedge clk);

    misaligned("LH mis", 3'b001, 32'h401);
    @(negedge clk);
    misaligned("LW mis", 3'b000, 32'h402);
    @(negedge clk);

    r = '{1'b0, 32'h0000_0010, 32'h0, 4'b0000};
    access("LW 0x10", 1'b0, 1'b1, 3'b000, 2'b00, 32'h10, 32'h0, 32'h1111_1111, 0, r, 32'h1111_1111, c1);
    r = '{1'b0, 32'h0000_0014, 32'h0, 4'b0000};
    access("LHU 0x16", 1'b0, 1'b1, 3'b010, 2'b00, 32'h16, 32'h0, 32'hABCD_0000, 0, r, 32'h0000_ABCD, c2);
    check("b2b req spacing", 32'(c2 - c1), 32'd3);
    set_op(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    @(negedge clk);

    // Abandon a store mid-BUSY with a reset
    set_op(1'b1, 1'b0, 3'b000, 2'b00, 32'h500, 32'hCAFE_F00D);
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      #1;
      got = dmem_req;
    end
    check("rst pre req", 32'(got), 32'd1);
    rst = 1'b1;
    set_op(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    check("rst req", 32'(dmem_req), 32'd0);
    check("rst we", 32'(dmem_we), 32'd0);
    check("rst addr", dmem_addr, 32'h0);
    check("rst wdata", dmem_wdata, 32'h0);
    check("rst wstrb", 32'(dmem_wstrb), 32'd0);
    check("rst memdata", MemData_MEM, 32'h0);
    rst        = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    #1;
    dmem_ack = 1'b0;
    check("stray ack req", 32'(dmem_req), 32'd0);
    check("stray ack stall", 32'(mem_stall), 32'd0);
    check("stray ack memdata", MemData_MEM, 32'h0);

    r = '{1'b0, 32'h0000_0020, 32'h0, 4'b0000};
    access("LH post rst", 1'b0, 1'b1, 3'b001, 2'b00, 32'h22, 32'h0, 32'h8001_0000, 0, r, 32'hFFFF_8001, cr);
    set_op(1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    check("idle memdata", MemData_MEM, 32'h0);
    check("scoreboard empty", 32'(req_q.size() + res_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
